fifo_read_fsm: RTL and testbench

//  Read-side controller for the encoder FIFO; counterpart of the write-enable FSM that fills it.

---
 rtl/fifo_read_fsm_pkg.sv | 14 +
 rtl/fifo_read_fsm_out_buf2.sv | 64 ++++++
 rtl/fifo_read_fsm.sv | 108 ++++++++++
 tb/tb_fifo_read_fsm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_fsm_pkg.sv
// Shared definitions for the encoder FIFO read-side controller.
package fifo_read_fsm_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 5;

  // Encodings line up with the write-enable FSM on the fill side.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_read_fsm_out_buf2.sv
// Two-entry FIFO-ordered skid buffer that absorbs the one-cycle FIFO read latency.
module fifo_read_fsm_out_buf2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              valid_q, valid_d;

  // Slot 0 is always the stream head; slot 1 only holds data while slot 0 is stalled.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push && pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        tail_d = wdata;
      end else begin
        head_d = wdata;
      end
    end else if (push) begin
      if (occ_q == 2'd0) begin
        head_d = wdata;
      end else begin
        tail_d = wdata;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_read_fsm.sv
// Read-side controller: drains len FIFO entries onto a valid/ready stream at one word per cycle.
module fifo_read_fsm
  import fifo_read_fsm_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              fifo_empty,
  output logic              fifo_re,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic              done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;

  logic             xfer_c;
  logic             fifo_re_c;
  logic [1:0]       occ;
  logic [2:0]       pending_c;

  fifo_read_fsm_out_buf2 #(
    .DATA_W (DATA_W)
  ) u_out_buf2 (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .wdata (fifo_rdata),
    .pop   (xfer_c),
    .head  (out_data),
    .valid (out_valid),
    .occ   (occ)
  );

  // Credit: a new read is allowed only if its word is guaranteed a buffer slot.
  always_comb begin
    xfer_c    = out_valid & out_ready;
    pending_c = 3'(occ) + 3'(inflight_q) - 3'(xfer_c);
    fifo_re_c = (state_q == ST_READING) & ~fifo_empty
              & (issued_q != len_q) & (pending_c < 3'd2);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_count_d = rd_count_q;
    inflight_d = fifo_re_c;
    if (fifo_re_c) begin
      issued_d = issued_q + CNT_W'(1);
    end
    if (xfer_c) begin
      rd_count_d = rd_count_q + CNT_W'(1);
    end
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_d      = len;
          issued_d   = '0;
          rd_count_d = '0;
          state_d    = (len == '0) ? ST_DONE : ST_READING;
        end
      end
      ST_READING: begin
        if (xfer_c && (rd_count_q == len_q - CNT_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign fifo_re  = fifo_re_c;
  assign rd_count = rd_count_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fifo_read_fsm.sv
// Bench for fifo_read_fsm: FIFO environment, stream scoreboard model, directed scenarios.
module tb_fifo_read_fsm;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          fifo_empty;
  logic          fifo_re;
  logic [DW-1:0] fifo_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic          done;
  logic          force_empty = 1'b0;

  // FIFO environment: synchronous read, data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:63];
  int            rd_ptr = 0;
  int            wr_ptr = 0;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (fifo_re && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always #5 clock = ~clock;

  fifo_read_fsm #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_rdata (fifo_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_count   (rd_count),
    .done       (done)
  );

  int            vectors = 0;
  int            errors  = 0;
  bit            chk_en  = 1'b0;
  int            m_len = 0, m_cnt = 0, m_reads = 0;
  bit            m_active = 1'b0, m_done = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] sb_q [$];
  int            chk_ptr = 0;
  logic [DW-1:0] xlog [0:63];
  int            xtotal = 0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Stream model: words leave in FIFO order, at most len, at most two outstanding.
  task automatic model_check();
    bit pop;
    pop = out_valid && out_ready;
    if (chk_en && reset) begin
      chk("done", int'(done), int'(m_done));
      chk("rd_count", int'(rd_count), m_cnt);
      if (hold_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(hold_data));
      end
      if (fifo_re) begin
        chk("re_when_empty", int'(fifo_empty), 0);
        chk("re_credit", int'((int'(sb_q.size()) - int'(pop)) < 2), 1);
        chk("re_overread", int'(m_active && (m_reads < m_len)), 1);
      end
      if (pop) begin
        if (sb_q.size() == 0) chk("xfer_unexpected", int'(out_valid), 0);
        else chk("xfer_data", int'(out_data), int'(sb_q.pop_front()));
        xlog[xtotal % 64] = out_data;
        xtotal++;
      end
    end
    hold_prev = reset && out_valid && !out_ready;
    hold_data = out_data;
    if (fifo_re && !fifo_empty) begin
      sb_q.push_back(mem[chk_ptr]);
      chk_ptr++;
    end
    if (!reset) begin
      sb_q.delete();
      m_cnt = 0; m_reads = 0; m_active = 1'b0; m_done = 1'b0;
    end else begin
      if (fifo_re) m_reads++;
      if (pop) begin
        m_cnt++;
        if (m_active && (m_cnt == m_len)) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (start && !m_active) begin
        m_len = int'(len); m_cnt = 0; m_reads = 0;
        m_active = (len != '0);
        m_done   = (len == '0);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clock);
    model_check();
  endtask

  task automatic to_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_pos();
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + DW'(i);
      wr_ptr++;
    end
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len   = CW'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      at_neg();
      seen = done;
      to_pos();
    end
    chk("done_timeout", int'(seen), 1);
  endtask

  initial begin
    bit seen;

    // Reset held two cycles with start high; outputs cleared, idle afterwards.
    reset = 1'b0; start = 1'b1; len = CW'(5);
    tick(); tick();
    reset = 1'b1; start = 1'b0;
    at_neg();
    chk("rst_fifo_re", int'(fifo_re), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_rd_count", int'(rd_count), 0);
    chk("rst_done", int'(done), 0);
    to_pos();
    chk_en = 1'b1;
    at_neg();
    chk("idle_done", int'(done), 0);
    chk("idle_valid", int'(out_valid), 0);
    to_pos();

    // len == 0: straight to done, never reads.
    load(8'h50, 1);
    pulse_start(0);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("len0_done", int'(done), 1);
      chk("len0_re", int'(fifo_re), 0);
      chk("len0_rd_count", int'(rd_count), 0);
      to_pos();
    end
    wr_ptr = rd_ptr;

    // Full-rate drain of four words; timeline relative to the start-sampling edge.
    load(8'h10, 4);
    out_ready = 1'b1;
    pulse_start(4);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("t2_re", int'(fifo_re), int'(k <= 3));
      chk("t2_valid", int'(out_valid), int'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("t2_data", int'(out_data), 8'h10 + k - 2);
      chk("t2_done", int'(done), int'(k >= 6));
      to_pos();
    end
    chk("t2_rd_count", int'(rd_count), 4);

    // Backpressure pattern 1,0,0,1 with an ignored start while reading.
    load(8'h30, 4);
    out_ready = 1'b1;
    pulse_start(4);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      start     = (i == 3);
      len       = (i == 3) ? CW'(9) : CW'(4);
      at_neg();
      seen = done;
      to_pos();
    end
    start = 1'b0;
    chk("t3_done_timeout", int'(seen), 1);
    chk("t3_rd_count", int'(rd_count), 4);
    chk("t3_last_word", int'(xlog[(xtotal - 1) % 64]), 8'h33);

    // FIFO empty for five cycles mid-stream.
    load(8'h40, 3);
    out_ready = 1'b1;
    pulse_start(3);
    tick();
    force_empty = 1'b1;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t4_gap_re", int'(fifo_re), 0);
      to_pos();
    end
    force_empty = 1'b0;
    wait_done(30);
    chk("t4_rd_count", int'(rd_count), 3);
    chk("t4_last_word", int'(xlog[(xtotal - 1) % 64]), 8'h42);

    // Reset with two words buffered, then a fresh short run.
    load(8'h60, 8);
    out_ready = 1'b0;
    pulse_start(8);
    repeat (3) tick();
    at_neg();
    chk("t6_full_valid", int'(out_valid), 1);
    chk("t6_full_data", int'(out_data), 8'h60);
    chk("t6_full_re", int'(fifo_re), 0);
    to_pos();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    at_neg();
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_rd_count", int'(rd_count), 0);
    chk("t6_rst_done", int'(done), 0);
    to_pos();
    out_ready = 1'b1;
    pulse_start(2);
    wait_done(20);
    chk("t6_rd_count", int'(rd_count), 2);
    chk("t6_word0", int'(xlog[(xtotal - 2) % 64]), 8'h62);
    chk("t6_word1", int'(xlog[(xtotal - 1) % 64]), 8'h63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
